// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the request, ALU-drive, ALU-result and response
// signals of the ALU issue controller.
//   slave  - controller view (alu_issue_ctrl)
//   master - environment view (decode stage, ALU and result consumer)
interface alu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_shamt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shift;
  logic [31:0] alu_y;
  logic [31:0] alu_less;
  logic        alu_ovf;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        ovf_trap;
  logic        trap_clr;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt,
    input  alu_y, alu_less, alu_ovf, alu_zero,
    input  rsp_ready, trap_clr,
    output req_ready, alu_a, alu_b, alu_op, alu_shift,
    output rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err, ovf_trap
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt,
    output alu_y, alu_less, alu_ovf, alu_zero,
    output rsp_ready, trap_clr,
    input  req_ready, alu_a, alu_b, alu_op, alu_shift,
    input  rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err, ovf_trap
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues abstract ALU requests onto the ALUop/Shift pins of the
// combinational 32-bit ALU, holds the operands for one execute cycle, captures
// Y/Less/Overflow/ZERO and returns the result on a valid/ready interface.
// Latency 2 cycles from accept to rsp_valid; one op per 2 cycles.
// Optional feature macro: ALU_ISSUE_OVF_TRAP_EN (sticky overflow trap that
// blocks new requests until trap_clr).
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  // Abstract opcode to ALU ALUop pin encoding.
  function automatic logic [3:0] encode_op(input logic [3:0] op);
    logic [3:0] code;
    code = 4'b0000;
    case (op)
      4'd0:    code = 4'b0000;  // ADD
      4'd1:    code = 4'b1000;  // SUB
      4'd2:    code = 4'b0001;  // SLL
      4'd3:    code = 4'b0010;  // SLT
      4'd4:    code = 4'b0100;  // XOR
      4'd5:    code = 4'b0101;  // SRL
      4'd6:    code = 4'b1101;  // SRA
      4'd7:    code = 4'b0110;  // OR
      4'd8:    code = 4'b0111;  // AND
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'd8);
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        trap_q;
  logic        vld_p0;

  // Op class travelling with the operands into the execute stage.
  logic        is_slt_p0;
  logic        is_addsub_p0;
  logic        is_ill_p0;

  logic [31:0] res_data;
  logic        res_zero;
  logic        res_ovf;

  assign bus.req_ready = ((state == IDLE) | ((state == RESP) & bus.rsp_ready)) & ~trap_q;
  assign accept        = bus.req_valid & bus.req_ready;
  assign vld_p0        = (state == EXEC);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: accept from IDLE or back-to-back from RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: accept edge, drive ALU pins and latch op class ----
  // ALU drive registers; an illegal opcode leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.alu_shift <= '0;
    end else if (accept && op_legal(bus.req_op)) begin
      bus.alu_a     <= bus.req_a;
      bus.alu_b     <= bus.req_b;
      bus.alu_op    <= encode_op(bus.req_op);
      bus.alu_shift <= bus.req_shamt;
    end
  end

  // Op class flags used when the result is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_slt_p0    <= 1'b0;
      is_addsub_p0 <= 1'b0;
      is_ill_p0    <= 1'b0;
    end else if (accept) begin
      is_slt_p0    <= (bus.req_op == 4'd3);
      is_addsub_p0 <= (bus.req_op == 4'd0) | (bus.req_op == 4'd1);
      is_ill_p0    <= ~op_legal(bus.req_op);
    end
  end

  // Result selection; overflow is masked for non-ADD/SUB because the ALU
  // leaves that pin undefined there.
  always_comb begin
    res_data = '0;
    res_zero = 1'b1;
    res_ovf  = 1'b0;
    if (!is_ill_p0) begin
      res_data = is_slt_p0 ? bus.alu_less : bus.alu_y;
      res_zero = is_addsub_p0 ? bus.alu_zero : (res_data == 32'd0);
      res_ovf  = is_addsub_p0 ? bus.alu_ovf : 1'b0;
    end
  end

  // ---- stage p1: capture edge, response registers ----
  // rsp_valid mirrors residency in RESP; data is captured only out of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_ovf   <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= (state_nxt == RESP);
      if (vld_p0) begin
        bus.rsp_data <= res_data;
        bus.rsp_zero <= res_zero;
        bus.rsp_ovf  <= res_ovf;
        bus.rsp_err  <= is_ill_p0;
      end
    end
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  // Sticky overflow trap; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          trap_q <= 1'b0;
    else if (vld_p0 && res_ovf)          trap_q <= 1'b1;
    else if (bus.trap_clr)               trap_q <= 1'b0;
  end
`else
  logic unused_trap_clr;
  assign trap_q          = 1'b0;
  assign unused_trap_clr = bus.trap_clr;
`endif

  assign bus.ovf_trap = trap_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural ALU.
// The ALU model drives deliberately wrong Overflow/ZERO for non-ADD/SUB ops so
// the controller's masking and local zero detection are observable.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_issue_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    logic [31:0] y;
    y = 32'h0;
    bus.alu_ovf = 1'b1;
    case (bus.alu_op)
      4'b0000: begin
        y = bus.alu_a + bus.alu_b;
        bus.alu_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (y[31] != bus.alu_a[31]);
      end
      4'b1000: begin
        y = bus.alu_a - bus.alu_b;
        bus.alu_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (y[31] != bus.alu_a[31]);
      end
      4'b0001: y = bus.alu_a << bus.alu_shift;
      4'b0010: y = bus.alu_a - bus.alu_b;
      4'b0100: y = bus.alu_a ^ bus.alu_b;
      4'b0101: y = bus.alu_a >> bus.alu_shift;
      4'b1101: y = $unsigned($signed(bus.alu_a) >>> bus.alu_shift);
      4'b0110: y = bus.alu_a | bus.alu_b;
      4'b0111: y = bus.alu_a & bus.alu_b;
      default: y = 32'h0;
    endcase
    bus.alu_y    = y;
    bus.alu_less = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
    if (bus.alu_op == 4'b0000 || bus.alu_op == 4'b1000) bus.alu_zero = (y == 32'd0);
    else                                                bus.alu_zero = (y != 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the next edge accept it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_shamt = sh;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = '0; bus.req_b = '0;
    bus.req_shamt = '0; bus.rsp_ready = 1'b0; bus.trap_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_tests++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shift} !== 73'd0) begin
      n_fail++; $display("FAIL reset_alu got %h %h %h %h want 0", bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shift);
    end
    n_tests++;
    if ({bus.rsp_data, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err, bus.ovf_trap} !== 36'd0) begin
      n_fail++; $display("FAIL reset_rsp got %h %b%b%b trap %b want 0", bus.rsp_data, bus.rsp_zero,
                         bus.rsp_ovf, bus.rsp_err, bus.ovf_trap);
    end
  endtask

  task automatic test_add_ovf();
    bus.rsp_ready = 1'b1;
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    n_tests++;
    if (bus.alu_op !== 4'b0000 || bus.alu_a !== 32'h7FFF_FFFF || bus.alu_b !== 32'd1) begin
      n_fail++; $display("FAIL add_alu_drive got op %b a %h b %h want 0000 7fffffff 1", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL add_exec_hs got rsp_valid %b req_ready %b want 0 0", bus.rsp_valid, bus.req_ready);
    end
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_zero, bus.rsp_err} !== {1'b1, 32'h8000_0000, 3'b100}) begin
      n_fail++; $display("FAIL add_result got v %b d %h ovf %b z %b err %b want 1 80000000 1 0 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_zero, bus.rsp_err);
    end
`ifdef ALU_ISSUE_OVF_TRAP_EN
    n_tests++;
    if (bus.ovf_trap !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL trap_set got trap %b req_ready %b want 1 0", bus.ovf_trap, bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.ovf_trap !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL trap_hold got v %b trap %b req_ready %b want 0 1 0", bus.rsp_valid, bus.ovf_trap, bus.req_ready);
    end
    bus.trap_clr = 1'b1;
    tick();
    bus.trap_clr = 1'b0;
    n_tests++;
    if (bus.ovf_trap !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL trap_clr got trap %b req_ready %b want 0 1", bus.ovf_trap, bus.req_ready);
    end
`else
    n_tests++;
    if (bus.ovf_trap !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_trap got trap %b req_ready %b want 0 1", bus.ovf_trap, bus.req_ready);
    end
    bus.trap_clr = 1'b1;
    tick();
    bus.trap_clr = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_to_idle got v %b req_ready %b want 0 1", bus.rsp_valid, bus.req_ready);
    end
`endif
  endtask

  task automatic test_sub_zero();
    issue(4'd1, 32'd5, 32'd5, 5'd0);
    n_tests++;
    if (bus.alu_op !== 4'b1000) begin n_fail++; $display("FAIL sub_alu_op got %b want 1000", bus.alu_op); end
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err} !== {1'b1, 32'd0, 3'b100}) begin
      n_fail++; $display("FAIL sub_result got v %b d %h z %b ovf %b err %b want 1 0 1 0 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err);
    end
    tick();
  endtask

  task automatic test_slt_sra_b2b();
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0);
    n_tests++;
    if (bus.alu_op !== 4'b0010) begin n_fail++; $display("FAIL slt_alu_op got %b want 0010", bus.alu_op); end
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ovf} !== {1'b1, 32'd1, 2'b00}) begin
      n_fail++; $display("FAIL slt_result got v %b d %h z %b ovf %b want 1 1 0 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ovf);
    end
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready got %b want 1", bus.req_ready); end
    issue(4'd6, 32'h8000_0000, 32'd0, 5'd4);
    n_tests++;
    if (bus.alu_op !== 4'b1101 || bus.alu_shift !== 5'd4 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL sra_drive got op %b sh %0d v %b want 1101 4 0", bus.alu_op, bus.alu_shift, bus.rsp_valid);
    end
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ovf} !== {1'b1, 32'hF800_0000, 2'b00}) begin
      n_fail++; $display("FAIL sra_result got v %b d %h z %b ovf %b want 1 f8000000 0 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ovf);
    end
    issue(4'd4, 32'h1234_5678, 32'h1234_5678, 5'd0);
    tick();
    n_tests++;
    if ({bus.rsp_data, bus.rsp_zero, bus.rsp_ovf} !== {32'd0, 2'b10}) begin
      n_fail++; $display("FAIL xor_zero got d %h z %b ovf %b want 0 1 0", bus.rsp_data, bus.rsp_zero, bus.rsp_ovf);
    end
    issue(4'd2, 32'h0000_0003, 32'd0, 5'd30);
    tick();
    n_tests++;
    if ({bus.alu_op, bus.rsp_data, bus.rsp_zero} !== {4'b0001, 32'hC000_0000, 1'b0}) begin
      n_fail++; $display("FAIL sll_result got op %b d %h z %b want 0001 c0000000 0", bus.alu_op, bus.rsp_data, bus.rsp_zero);
    end
    issue(4'd5, 32'h8000_0000, 32'd0, 5'd4);
    tick();
    n_tests++;
    if ({bus.alu_op, bus.rsp_data} !== {4'b0101, 32'h0800_0000}) begin
      n_fail++; $display("FAIL srl_result got op %b d %h want 0101 08000000", bus.alu_op, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    issue(4'd7, 32'h0000_00F0, 32'h0000_0F00, 5'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_0FF0 || bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL or_hold[%0d] got v %b d %h req_ready %b want 1 00000ff0 0",
                           i, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 4'd8; bus.req_a = 32'hFF00_FF00; bus.req_b = 32'h0FF0_0FF0;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready got %b want 1", bus.req_ready); end
    issue(4'd8, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    n_tests++;
    if (bus.alu_op !== 4'b0111 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL and_accept got op %b v %b want 0111 0", bus.alu_op, bus.rsp_valid);
    end
    tick();
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0F00_0F00) begin
      n_fail++; $display("FAIL and_result got v %b d %h want 1 0f000f00", bus.rsp_valid, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(4'd12, 32'h0000_0123, 32'h0000_0456, 5'd3);
    n_tests++;
    if (bus.alu_op !== 4'b0111 || bus.alu_a !== 32'hFF00_FF00 || bus.alu_shift !== 5'd0) begin
      n_fail++; $display("FAIL ill_alu_hold got op %b a %h sh %0d want 0111 ff00ff00 0", bus.alu_op, bus.alu_a, bus.alu_shift);
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ill_latency got v %b want 0", bus.rsp_valid); end
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_zero, bus.rsp_ovf} !== {1'b1, 32'd0, 3'b110}) begin
      n_fail++; $display("FAIL ill_result got v %b d %h err %b z %b ovf %b want 1 0 1 1 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_zero, bus.rsp_ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(4'd1, 32'd9, 32'd2, 5'd7);
    n_tests++;
    if (bus.alu_op !== 4'b1000 || bus.alu_a !== 32'd9) begin
      n_fail++; $display("FAIL mid_pre got op %b a %h want 1000 9", bus.alu_op, bus.alu_a);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shift, bus.rsp_valid, bus.rsp_data, bus.ovf_trap} !== 107'd0) begin
      n_fail++; $display("FAIL mid_reset got a %h op %b sh %0d v %b d %h want 0",
                         bus.alu_a, bus.alu_op, bus.alu_shift, bus.rsp_valid, bus.rsp_data);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_dropped got v %b req_ready %b want 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_slt_sra_b2b();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/capture controller that initiates operations on the combinational 32-bit ALU (`ADD_32` + `Shift` datapath). It accepts abstract operation requests on a valid/ready interface, encodes them onto the ALU's `ALUop`/`Shift` control pins, and registers the operands for a full execute cycle. It then captures `Y`/`Less`/`Overflow`/`ZERO` into a result register and returns the result on a second valid/ready interface. It sits between the decode stage and the ALU and is the sole driver of the ALU inputs.

## Interface
- No parameters; data width fixed at 32, shift amount at 5.
- `clk  in  1`  sole clock, rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `req_valid  in  1`  request present.
- `req_ready  out  1`  controller can accept the request.
- `req_op  in  4`  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 XOR, 5 SRL, 6 SRA, 7 OR, 8 AND, 9–15 illegal.
- `req_a`, `req_b`  in  32  operands.
- `req_shamt  in  5`  shift amount.
- `alu_a`, `alu_b`  out  32  registered operands to ALU `A`/`B`.
- `alu_op  out  4`  registered ALU `ALUop`.
- `alu_shift  out  5`  registered ALU `Shift`.
- `alu_y  in  32`, `alu_less  in  32`, `alu_ovf  in  1`, `alu_zero  in  1`  ALU outputs.
- `rsp_valid  out  1`  result present.
- `rsp_ready  in  1`  consumer accepts the result.
- `rsp_data  out  32`  result.
- `rsp_zero  out  1`  result-zero flag.
- `rsp_ovf  out  1`  signed overflow; valid for ADD/SUB only.
- `rsp_err  out  1`  illegal opcode.
- `ovf_trap  out  1`  sticky overflow trap (see Configuration).
- `trap_clr  in  1`  clears `ovf_trap`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch operands, encode op, go to EXEC.
- EXEC: ALU inputs are held stable for one full cycle. At the next edge, capture the result and go to RESP.
- RESP: `rsp_valid`=1, outputs held stable until `rsp_ready`.
  - `rsp_ready` with no new request: go to IDLE.
  - `rsp_ready` with `req_valid`: accept the new request in the same cycle and go to EXEC (back-to-back).
- `req_ready` = (state==IDLE) | (state==RESP & `rsp_ready`), gated by trap when enabled. Combinational from `rsp_ready`; no combinational path from `req_valid`.
- Opcode to `alu_op` encoding:
  - ADD 4'b0000, SUB 4'b1000, SLL 4'b0001, SLT 4'b0010
  - XOR 4'b0100, SRL 4'b0101, SRA 4'b1101, OR 4'b0110, AND 4'b0111
- `alu_shift` = `req_shamt` for all ops; don't-care for non-shift ops.
- Result capture:
  - `rsp_data` = `alu_less` for SLT, `alu_y` for all other ops.
  - `rsp_ovf` = `alu_ovf` for ADD/SUB, else 0. The ALU drives X on this pin for other ops, so it must never propagate.
  - `rsp_zero` = `alu_zero` for ADD/SUB. For all other ops, `rsp_zero` = (`rsp_data`==0), computed locally.
- Illegal opcode:
  - `alu_*` registers are not updated.
  - Still passes through EXEC, for uniform latency.
  - Captures `rsp_data`=0, `rsp_err`=1, `rsp_zero`=1, `rsp_ovf`=0.
- `rsp_err`=0 for all legal ops.

## Timing
- Request accepted at edge N. `alu_*` are valid after edge N. Result captured at edge N+1, so `rsp_valid` is high after N+1 (latency 2).
- Throughput: one op per 2 cycles with `rsp_ready` held high.
- All `rsp_*` and `alu_*` outputs are registered.
- Reset values: state IDLE; `alu_a`/`alu_b`/`alu_op`/`alu_shift`=0; `rsp_valid`/`rsp_data`/`rsp_zero`/`rsp_ovf`/`rsp_err`=0; `ovf_trap`=0.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is dropped and no response is issued.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Configuration
- `ALU_ISSUE_OVF_TRAP_EN` defined:
  - A captured ADD/SUB with `alu_ovf`=1 sets `ovf_trap` at the capture edge.
  - While `ovf_trap`=1, `req_ready`=0. The pending response still completes.
  - `trap_clr` clears the trap at the next edge. If `trap_clr` coincides with a new setting event, set wins.
- `ALU_ISSUE_OVF_TRAP_EN` undefined:
  - `ovf_trap` is tied 0 and `trap_clr` is ignored.
  - Overflow is reported only via `rsp_ovf`.

## Test plan
- ADD 0x7FFFFFFF + 1, `rsp_ready`=1 → `alu_op`=0000 one cycle after accept; two cycles after accept `rsp_data`=0x80000000, `rsp_ovf`=1, `rsp_zero`=0.
- SUB 5 − 5 → `alu_op`=1000, `rsp_data`=0, `rsp_zero`=1, `rsp_ovf`=0.
- SLT a=0xFFFFFFFF(−1), b=1 → `rsp_data`=1. Then SRA a=0x80000000, shamt=4 → `alu_op`=1101, `rsp_data`=0xF8000000.
- `rsp_ready` held low 5 cycles after an OR result → `rsp_valid`/`rsp_data` stable and `req_ready`=0. Then raise `rsp_ready` with `req_valid`=1 (AND) → accepted in the same cycle, AND response 2 cycles later.
- `req_op`=12 → `rsp_err`=1, `rsp_data`=0, `alu_op` unchanged from the previous op.
- With `ALU_ISSUE_OVF_TRAP_EN`: overflowing ADD → `ovf_trap`=1 and `req_ready`=0. Pulse `trap_clr` → `req_ready` returns high. Also assert `rst_n`=0 during EXEC → all outputs are 0 immediately.
